// File: rtl/vga_fb_reader.sv
// ---------------------------------------------------------------------------
// vga_fb_reader
//   Wishbone read master that streams a framebuffer (HDISP*VDISP 32-bit words
//   starting at FB_BASE) into the write side of the VGA pixel FIFO, using
//   fixed-length incrementing bursts of BURST words. A new burst is only
//   started from IDLE when the FIFO reports room for a whole burst, so a
//   burst in flight is never aborted. The address wraps to FB_BASE at the
//   end of each frame, and also whenever the reader idles with en low.
//
// Optional feature (macro VGA_FB_READER_ERR_EN):
//   adds wshb_err input and sticky err_flag output. An err beat is
//   sequenced exactly like an ack but pushes 32'h0 into the FIFO so the
//   frame stays aligned.
//
// Ports:
//   wshb_clk, wshb_rst     clock, synchronous active-high reset
//   en                     streaming enable
//   wshb_adr/cyc/stb/we/sel/cti/bte   Wishbone master request
//   wshb_dat_sm, wshb_ack  Wishbone read data / acknowledge
//   wshb_err, err_flag     bus error input / sticky error flag (optional)
//   fifo_walmost_full      fewer than BURST free FIFO slots
//   fifo_write, fifo_wdata FIFO push strobe / data
//   frame_done             one-cycle pulse on the last word of a frame
// ---------------------------------------------------------------------------
module vga_fb_reader #(
    parameter int          HDISP   = 800,
    parameter int          VDISP   = 480,
    parameter logic [31:0] FB_BASE = 32'h0,
    parameter int          BURST   = 16
) (
    input  logic        wshb_clk,
    input  logic        wshb_rst,
    input  logic        en,
    output logic [31:0] wshb_adr,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    input  logic [31:0] wshb_dat_sm,
    input  logic        wshb_ack,
`ifdef VGA_FB_READER_ERR_EN
    input  logic        wshb_err,
    output logic        err_flag,
`endif
    input  logic        fifo_walmost_full,
    output logic        fifo_write,
    output logic [31:0] fifo_wdata,
    output logic        frame_done
);

    localparam int TOTAL = HDISP * VDISP;
    localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int BW    = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t        state_q, state_d;
    logic [31:0]   adr_q, adr_d;
    logic [2:0]    cti_q, cti_d;
    logic [IW-1:0] word_q, word_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [BW-1:0] beat_nxt;

    logic in_burst;
    logic err_beat;
    logic bus_ev;
    logic last_beat;
    logic last_word;
    logic start;

    assign in_burst  = (state_q == S_BURST);
    assign beat_nxt  = beat_q + 1'b1;
    assign last_beat = (beat_q == BW'(BURST - 1));
    assign last_word = (word_q == IW'(TOTAL - 1));
    assign start     = en & ~fifo_walmost_full;

`ifdef VGA_FB_READER_ERR_EN
    logic err_flag_q, err_flag_d;
    assign err_beat = wshb_err & in_burst & ~wshb_rst;
    assign err_flag = err_flag_q;
`else
    assign err_beat = 1'b0;
`endif

    // A beat completes on ack (or err). Gating with reset keeps a beat that
    // lands in the reset cycle from reaching the FIFO.
    assign bus_ev = (wshb_ack | err_beat) & in_burst & ~wshb_rst;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge wshb_clk) begin
        if (wshb_rst) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)                state_d = S_BURST;
            S_BURST: if (bus_ev && last_beat)  state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        wshb_cyc   = in_burst;
        wshb_stb   = in_burst;
        wshb_we    = 1'b0;
        wshb_sel   = 4'b1111;
        wshb_bte   = 2'b00;
        wshb_adr   = adr_q;
        wshb_cti   = cti_q;
        fifo_write = bus_ev;
        fifo_wdata = err_beat ? 32'h0 : wshb_dat_sm;
        frame_done = bus_ev & last_word;
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        adr_d  = adr_q;
        cti_d  = cti_q;
        word_d = word_q;
        beat_d = beat_q;
        if (!in_burst) begin
            // Idling disabled rewinds to pixel (0,0) so re-enable is clean.
            if (!en) begin
                adr_d  = FB_BASE;
                word_d = '0;
            end
            if (start) cti_d = (BURST == 1) ? CTI_END : CTI_INCR;
        end else if (bus_ev) begin
            beat_d = last_beat ? '0 : beat_nxt;
            if (last_word) begin
                adr_d  = FB_BASE;
                word_d = '0;
            end else begin
                adr_d  = adr_q + 32'd4;
                word_d = word_q + 1'b1;
            end
            // Mark the final beat as pending once the counter reaches BURST-1.
            if (last_beat)                        cti_d = CTI_CLASSIC;
            else if (beat_nxt == BW'(BURST - 1))  cti_d = CTI_END;
            else                                  cti_d = CTI_INCR;
        end
    end

    always_ff @(posedge wshb_clk) begin
        if (wshb_rst) begin
            adr_q  <= FB_BASE;
            cti_q  <= CTI_CLASSIC;
            word_q <= '0;
            beat_q <= '0;
        end else begin
            adr_q  <= adr_d;
            cti_q  <= cti_d;
            word_q <= word_d;
            beat_q <= beat_d;
        end
    end

`ifdef VGA_FB_READER_ERR_EN
    always_comb begin
        err_flag_d = err_flag_q | err_beat;
    end

    always_ff @(posedge wshb_clk) begin
        if (wshb_rst) err_flag_q <= 1'b0;
        else          err_flag_q <= err_flag_d;
    end
`endif

endmodule

// File: tb/tb_vga_fb_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_reader
//   Directed bench for vga_fb_reader with HDISP=8, VDISP=2, BURST=4,
//   FB_BASE=0x100 (16-word frame, four bursts). The bench plays the
//   Wishbone slave and checks addresses, cycle types, pushes and frame wrap.
// ---------------------------------------------------------------------------
module tb_vga_fb_reader;

    localparam int          HDISP   = 8;
    localparam int          VDISP   = 2;
    localparam int          BURST   = 4;
    localparam logic [31:0] FB_BASE = 32'h100;

    logic        wshb_clk, wshb_rst, en;
    logic [31:0] wshb_adr;
    logic        wshb_cyc, wshb_stb, wshb_we;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic [31:0] wshb_dat_sm;
    logic        wshb_ack;
    logic        fifo_walmost_full;
    logic        fifo_write;
    logic [31:0] fifo_wdata;
    logic        frame_done;
`ifdef VGA_FB_READER_ERR_EN
    logic        wshb_err;
    logic        err_flag;
`endif

    int checks = 0;
    int errors = 0;
    int push_cnt = 0;

    vga_fb_reader #(
        .HDISP(HDISP), .VDISP(VDISP), .FB_BASE(FB_BASE), .BURST(BURST)
    ) dut (
        .wshb_clk(wshb_clk), .wshb_rst(wshb_rst), .en(en),
        .wshb_adr(wshb_adr), .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb),
        .wshb_we(wshb_we), .wshb_sel(wshb_sel), .wshb_cti(wshb_cti),
        .wshb_bte(wshb_bte), .wshb_dat_sm(wshb_dat_sm), .wshb_ack(wshb_ack),
`ifdef VGA_FB_READER_ERR_EN
        .wshb_err(wshb_err), .err_flag(err_flag),
`endif
        .fifo_walmost_full(fifo_walmost_full), .fifo_write(fifo_write),
        .fifo_wdata(fifo_wdata), .frame_done(frame_done)
    );

    initial begin
        wshb_clk = 1'b0;
        forever #5 wshb_clk = ~wshb_clk;
    end

    always @(negedge wshb_clk) if (fifo_write === 1'b1) push_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wshb_clk);
        #1;
    endtask

    task automatic wait_cyc(input int max_cyc, output int n);
        n = 0;
        while (wshb_cyc !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("cyc_rise", {31'd0, wshb_cyc}, 32'd1);
    endtask

    // Runs one whole burst as the slave; called while cyc is already high.
    task automatic run_burst(input logic [31:0] base, input int waits,
                             input bit fd_last, input int drop_en_at,
                             input int err_at);
        int          p0;
        logic [31:0] d;
        logic [2:0]  ecti;
        p0 = push_cnt;
        chk("burst_cyc", {31'd0, wshb_cyc}, 32'd1);
        chk("burst_stb", {31'd0, wshb_stb}, 32'd1);
        for (int i = 0; i < BURST; i++) begin
            ecti = (i == BURST - 1) ? 3'b111 : 3'b010;
            if (i == drop_en_at) en = 1'b0;
            for (int w = 0; w < waits; w++) begin
                wshb_ack = 1'b0;
                #1;
                chk("wait_adr", wshb_adr, base + 32'(4 * i));
                chk("wait_cti", {29'd0, wshb_cti}, {29'd0, ecti});
                chk("wait_nopush", {31'd0, fifo_write}, 32'd0);
                tick();
            end
            d = $urandom;
            wshb_dat_sm = d;
`ifdef VGA_FB_READER_ERR_EN
            if (i == err_at) begin
                wshb_err = 1'b1;
                d = 32'h0;
            end else begin
                wshb_ack = 1'b1;
            end
`else
            if (err_at >= 0) d = 32'h0;  // err never driven in this build
            wshb_ack = 1'b1;
`endif
            #1;
            chk("beat_adr", wshb_adr, base + 32'(4 * i));
            chk("beat_cti", {29'd0, wshb_cti}, {29'd0, ecti});
            chk("beat_push", {31'd0, fifo_write}, 32'd1);
            chk("beat_wdata", fifo_wdata, d);
            chk("beat_fdone", {31'd0, frame_done},
                {31'd0, (fd_last && i == BURST - 1)});
            tick();
            wshb_ack = 1'b0;
`ifdef VGA_FB_READER_ERR_EN
            wshb_err = 1'b0;
`endif
        end
        chk("end_cyc", {31'd0, wshb_cyc}, 32'd0);
        chk("end_cti", {29'd0, wshb_cti}, 32'd0);
        chk("burst_pushes", 32'(push_cnt - p0), 32'(BURST));
    endtask

    // One idle cycle between bursts, then the next burst starts.
    task automatic gap();
        chk("gap_cyc", {31'd0, wshb_cyc}, 32'd0);
        tick();
        chk("gap_rise", {31'd0, wshb_cyc}, 32'd1);
    endtask

    initial begin
        int n;
        int p0;
        int cyc_seen;
        wshb_rst = 1'b1;
        en = 1'b0;
        wshb_ack = 1'b0;
        wshb_dat_sm = 32'h0;
        fifo_walmost_full = 1'b0;
`ifdef VGA_FB_READER_ERR_EN
        wshb_err = 1'b0;
`endif
        repeat (3) tick();

        // reset state
        chk("rst_cyc", {31'd0, wshb_cyc}, 32'd0);
        chk("rst_stb", {31'd0, wshb_stb}, 32'd0);
        chk("rst_adr", wshb_adr, 32'h100);
        chk("rst_cti", {29'd0, wshb_cti}, 32'd0);
        chk("rst_push", {31'd0, fifo_write}, 32'd0);
        chk("rst_fdone", {31'd0, frame_done}, 32'd0);
        chk("const_we", {31'd0, wshb_we}, 32'd0);
        chk("const_sel", {28'd0, wshb_sel}, 32'hF);
        chk("const_bte", {30'd0, wshb_bte}, 32'd0);
`ifdef VGA_FB_READER_ERR_EN
        chk("rst_errflag", {31'd0, err_flag}, 32'd0);
`endif

        // full frame, zero wait states
        wshb_rst = 1'b0;
        en = 1'b1;
        wait_cyc(4, n);
        chk("first_latency", 32'(n), 32'd1);
        run_burst(32'h100, 0, 1'b0, -1, -1);
        gap();
        run_burst(32'h110, 0, 1'b0, -1, -1);
        gap();
        run_burst(32'h120, 0, 1'b0, -1, -1);
        gap();
        run_burst(32'h130, 0, 1'b1, -1, -1);
        chk("wrap_adr", wshb_adr, 32'h100);

        // almost-full held in IDLE
        fifo_walmost_full = 1'b1;
        p0 = push_cnt;
        cyc_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (wshb_cyc !== 1'b0) cyc_seen++;
        end
        chk("af_cyc_low", 32'(cyc_seen), 32'd0);
        chk("af_no_push", 32'(push_cnt - p0), 32'd0);
        fifo_walmost_full = 1'b0;
        wait_cyc(4, n);
        chk("af_release_le2", {31'd0, (n <= 2)}, 32'd1);

        // three wait states per beat
        run_burst(32'h100, 3, 1'b0, -1, -1);
        gap();

        // en dropped mid-burst: burst completes, idle rewinds address
        run_burst(32'h110, 0, 1'b0, 2, -1);
        tick();
        chk("endrop_adr", wshb_adr, 32'h100);
        chk("endrop_cyc", {31'd0, wshb_cyc}, 32'd0);
        repeat (3) tick();
        chk("endrop_hold", {31'd0, wshb_cyc}, 32'd0);
        en = 1'b1;
        wait_cyc(4, n);
        chk("reen_adr", wshb_adr, 32'h100);

        // reset at beat 1
        wshb_ack = 1'b1;
        wshb_dat_sm = 32'hDEAD0000;
        #1;
        chk("pre_rst_push", {31'd0, fifo_write}, 32'd1);
        tick();
        wshb_rst = 1'b1;
        #1;
        chk("rst_beat_push", {31'd0, fifo_write}, 32'd0);
        tick();
        wshb_ack = 1'b0;
        #1;
        chk("midrst_cyc", {31'd0, wshb_cyc}, 32'd0);
        chk("midrst_stb", {31'd0, wshb_stb}, 32'd0);
        chk("midrst_adr", wshb_adr, 32'h100);
        chk("midrst_push", {31'd0, fifo_write}, 32'd0);
        wshb_rst = 1'b0;
        wait_cyc(4, n);
        run_burst(32'h100, 0, 1'b0, -1, -1);

`ifdef VGA_FB_READER_ERR_EN
        gap();
        chk("pre_err_flag", {31'd0, err_flag}, 32'd0);
        run_burst(32'h110, 0, 1'b0, -1, 3);
        chk("err_flag_set", {31'd0, err_flag}, 32'd1);
        gap();
        run_burst(32'h120, 0, 1'b0, -1, -1);
        gap();
        run_burst(32'h130, 0, 1'b1, -1, -1);
        chk("err_flag_held", {31'd0, err_flag}, 32'd1);
`else
        gap();
        run_burst(32'h110, 0, 1'b0, -1, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
